// File: rtl/pc_ctrl_rv32_pkg.sv
// PC-select sequencer shared definitions: pc_src mux codes, FSM states, decode helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pc_ctrl_rv32_pkg;

  // Select codes understood by pc_muxrv32.
  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10,
    ST_MRET = 2'b11
  } pc_state_t;

  // The mux select is a pure function of the sequencer state.
  function automatic logic [1:0] pc_src_of(input pc_state_t s);
    case (s)
      ST_BOOT: pc_src_of = PC_SRC_BOOT;
      ST_RUN:  pc_src_of = PC_SRC_NEXT;
      ST_TRAP: pc_src_of = PC_SRC_TRAP;
      default: pc_src_of = PC_SRC_EPC;
    endcase
  endfunction

  // Everything except normal running discards the in-flight instruction.
  function automatic logic flush_of(input pc_state_t s);
    flush_of = (s != ST_RUN);
  endfunction

endpackage

// File: rtl/pc_ctrl_rv32.sv
// RV32 PC sequencer: owns the PC register and drives the pc_src select of pc_muxrv32.
// Latency: PC and all outputs are registered; an event in RUN shows on the outputs the next cycle.
// Backpressure: ahb_ready_in=0 holds pc_out (and the TRAP/MRET/BOOT exit); trap/mret are taken regardless.
//
// Ports:
//   clk_in, rst_n_in          clock (rising edge), async active-low reset
//   ahb_ready_in              instruction bus ready; PC loads only when 1
//   trap_req_in, mret_in      requests from CSR/decode (level)
//   misaligned_instr_in       from mux: taken branch target not 4-byte aligned
//   pc_mux_in                 selected next PC coming back from the mux
//   pc_src_out                mux select: 00 boot, 01 epc, 10 trap vector, 11 next_pc
//   pc_out                    current PC, fed to the mux pc_in
//   flush_out                 kill the instruction in fetch/decode
//   trap_taken_out/cause      1-cycle trap pulse; cause 1=misaligned fetch, 0=trap_req (held)
//   mret_taken_out            1-cycle pulse, CSR restores status
module pc_ctrl_rv32
  import pc_ctrl_rv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          BOOT_WAIT    = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ahb_ready_in,
  input  logic        trap_req_in,
  input  logic        mret_in,
  input  logic        misaligned_instr_in,
  input  logic [31:0] pc_mux_in,
  output logic [1:0]  pc_src_out,
  output logic [31:0] pc_out,
  output logic        flush_out,
  output logic        trap_taken_out,
  output logic        trap_cause_out,
  output logic        mret_taken_out
);

  // Counter wide enough for BOOT_WAIT-1, never narrower than one bit.
  localparam int              CNT_W   = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BOOT_WAIT - 1);

  pc_state_t        state;
  logic [CNT_W-1:0] boot_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_BOOT;
      boot_cnt       <= '0;
      pc_out         <= BOOT_ADDRESS;
      pc_src_out     <= pc_src_of(ST_BOOT);
      flush_out      <= flush_of(ST_BOOT);
      trap_taken_out <= 1'b0;
      trap_cause_out <= 1'b0;
      mret_taken_out <= 1'b0;
    end else begin
      // Pulses are high only in the first cycle of TRAP/MRET.
      trap_taken_out <= 1'b0;
      mret_taken_out <= 1'b0;

      case (state)
        ST_BOOT: begin
          if (boot_cnt != CNT_MAX) begin
            boot_cnt <= boot_cnt + 1'b1;
          end
          if ((boot_cnt == CNT_MAX) && ahb_ready_in) begin
            state      <= ST_RUN;
            pc_out     <= pc_mux_in;
            pc_src_out <= pc_src_of(ST_RUN);
            flush_out  <= flush_of(ST_RUN);
          end
        end

        ST_RUN: begin
          // Events win over a stalled fetch; the stale fetch is flushed.
          if (trap_req_in || misaligned_instr_in) begin
            state          <= ST_TRAP;
            pc_src_out     <= pc_src_of(ST_TRAP);
            flush_out      <= flush_of(ST_TRAP);
            trap_taken_out <= 1'b1;
            trap_cause_out <= !trap_req_in;
          end else if (mret_in) begin
            state          <= ST_MRET;
            pc_src_out     <= pc_src_of(ST_MRET);
            flush_out      <= flush_of(ST_MRET);
            mret_taken_out <= 1'b1;
          end else if (ahb_ready_in) begin
            pc_out <= pc_mux_in;
          end
        end

        ST_TRAP, ST_MRET: begin
          // Requests are ignored here; a held trap_req is re-taken once back in RUN.
          if (ahb_ready_in) begin
            state      <= ST_RUN;
            pc_out     <= pc_mux_in;
            pc_src_out <= pc_src_of(ST_RUN);
            flush_out  <= flush_of(ST_RUN);
          end
        end

        default: begin
          state      <= ST_BOOT;
          boot_cnt   <= '0;
          pc_src_out <= pc_src_of(ST_BOOT);
          flush_out  <= flush_of(ST_BOOT);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl_rv32.sv
// Directed bench for pc_ctrl_rv32 with a scoreboard queue and an independent monitor.
// Latency: each vector carries the outputs expected during the cycle it is driven in.
// Backpressure: ahb_ready_in is driven from the vector table.
module tb_pc_ctrl_rv32;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        ahb_ready_in = 1'b0;
  logic        trap_req_in = 1'b0;
  logic        mret_in = 1'b0;
  logic        misaligned_instr_in = 1'b0;
  logic [31:0] pc_mux_in = 32'h0;
  logic [1:0]  pc_src_out;
  logic [31:0] pc_out;
  logic        flush_out;
  logic        trap_taken_out;
  logic        trap_cause_out;
  logic        mret_taken_out;

  pc_ctrl_rv32 #(.BOOT_ADDRESS(32'h0000_0000), .BOOT_WAIT(4)) dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .ahb_ready_in        (ahb_ready_in),
    .trap_req_in         (trap_req_in),
    .mret_in             (mret_in),
    .misaligned_instr_in (misaligned_instr_in),
    .pc_mux_in           (pc_mux_in),
    .pc_src_out          (pc_src_out),
    .pc_out              (pc_out),
    .flush_out           (flush_out),
    .trap_taken_out      (trap_taken_out),
    .trap_cause_out      (trap_cause_out),
    .mret_taken_out      (mret_taken_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        trap;
    logic        mret;
    logic        mis;
    logic [31:0] mux;
    logic [1:0]  src;
    logic [31:0] pc;
    logic        flush;
    logic        tt;
    logic        tc;
    logic        mt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  src;
    logic [31:0] pc;
    logic        flush;
    logic        tt;
    logic        tc;
    logic        mt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic v(input logic rst_n, input logic rdy, input logic trap, input logic mret,
                   input logic mis, input logic [31:0] mux, input logic [1:0] src,
                   input logic [31:0] pc, input logic flush, input logic tt,
                   input logic tc, input logic mt);
    vec_t e;
    e.rst_n = rst_n; e.rdy = rdy; e.trap = trap; e.mret = mret; e.mis = mis; e.mux = mux;
    e.src = src; e.pc = pc; e.flush = flush; e.tt = tt; e.tc = tc; e.mt = mt;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  // Monitor: compare whatever the driver has posted, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_src", e.idx, 32'(pc_src_out), 32'(e.src));
        chk("pc",     e.idx, pc_out,          e.pc);
        chk("flush",  e.idx, 32'(flush_out),  32'(e.flush));
        chk("trap_taken", e.idx, 32'(trap_taken_out), 32'(e.tt));
        chk("trap_cause", e.idx, 32'(trap_cause_out), 32'(e.tc));
        chk("mret_taken", e.idx, 32'(mret_taken_out), 32'(e.mt));
      end
    end
  end

  initial begin
    exp_t e;
    //  rst rdy trp mrt mis  mux           src    pc            fl tt tc mt
    v(0, 1, 0, 0, 0, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 0  reset
    v(1, 1, 0, 0, 0, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 1  release, boot cnt 0
    v(1, 1, 1, 1, 1, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 2  requests ignored in BOOT
    v(1, 1, 0, 0, 0, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 3
    v(1, 1, 0, 0, 0, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 4  cnt==3 -> RUN
    v(1, 1, 0, 0, 0, 32'h4,   2'b11, 32'h0,   0, 0, 0, 0); // 5
    v(1, 1, 0, 0, 0, 32'h8,   2'b11, 32'h4,   0, 0, 0, 0); // 6
    v(1, 1, 0, 0, 0, 32'hC,   2'b11, 32'h8,   0, 0, 0, 0); // 7
    v(1, 1, 0, 0, 0, 32'h10,  2'b11, 32'hC,   0, 0, 0, 0); // 8
    v(1, 0, 0, 0, 0, 32'h14,  2'b11, 32'h10,  0, 0, 0, 0); // 9  wait states
    v(1, 0, 0, 0, 0, 32'h14,  2'b11, 32'h10,  0, 0, 0, 0); // 10
    v(1, 0, 0, 0, 0, 32'h14,  2'b11, 32'h10,  0, 0, 0, 0); // 11
    v(1, 1, 0, 0, 0, 32'h14,  2'b11, 32'h10,  0, 0, 0, 0); // 12
    v(1, 1, 0, 0, 0, 32'h18,  2'b11, 32'h14,  0, 0, 0, 0); // 13
    v(1, 1, 0, 0, 0, 32'h1C,  2'b11, 32'h18,  0, 0, 0, 0); // 14
    v(1, 1, 0, 0, 0, 32'h20,  2'b11, 32'h1C,  0, 0, 0, 0); // 15
    v(1, 1, 1, 1, 0, 32'h24,  2'b11, 32'h20,  0, 0, 0, 0); // 16 trap+mret: trap wins
    v(1, 1, 0, 0, 0, 32'h100, 2'b10, 32'h20,  1, 1, 0, 0); // 17 TRAP
    v(1, 1, 0, 0, 1, 32'h42,  2'b11, 32'h100, 0, 0, 0, 0); // 18 misaligned branch
    v(1, 0, 1, 1, 1, 32'h100, 2'b10, 32'h100, 1, 1, 1, 0); // 19 TRAP, requests ignored
    v(1, 1, 0, 0, 0, 32'h100, 2'b10, 32'h100, 1, 0, 1, 0); // 20
    v(1, 1, 0, 1, 0, 32'h104, 2'b11, 32'h100, 0, 0, 1, 0); // 21 mret
    v(1, 0, 0, 0, 0, 32'h24,  2'b01, 32'h100, 1, 0, 1, 1); // 22 MRET held
    v(1, 0, 0, 0, 0, 32'h24,  2'b01, 32'h100, 1, 0, 1, 0); // 23
    v(1, 1, 0, 0, 0, 32'h24,  2'b01, 32'h100, 1, 0, 1, 0); // 24
    v(1, 0, 1, 0, 0, 32'h28,  2'b11, 32'h24,  0, 0, 1, 0); // 25 trap while stalled
    v(0, 0, 0, 0, 0, 32'h100, 2'b00, 32'h0,   1, 0, 0, 0); // 26 async reset mid-TRAP
    v(0, 1, 1, 0, 0, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 27
    v(1, 1, 1, 0, 0, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 28 release, trap held
    v(1, 1, 1, 0, 0, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 29
    v(1, 1, 1, 0, 0, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 30
    v(1, 1, 1, 0, 0, 32'h0,   2'b00, 32'h0,   1, 0, 0, 0); // 31
    v(1, 1, 1, 0, 0, 32'h4,   2'b11, 32'h0,   0, 0, 0, 0); // 32 held trap re-taken
    v(1, 1, 0, 0, 0, 32'h100, 2'b10, 32'h0,   1, 1, 0, 0); // 33
    v(1, 1, 0, 0, 0, 32'h104, 2'b11, 32'h100, 0, 0, 0, 0); // 34

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk_in);
      #1;
      ahb_ready_in        = vecs[i].rdy;
      trap_req_in         = vecs[i].trap;
      mret_in             = vecs[i].mret;
      misaligned_instr_in = vecs[i].mis;
      pc_mux_in           = vecs[i].mux;
      // Reset moves between clock edges to exercise the asynchronous path.
      #2;
      rst_n_in = vecs[i].rst_n;
      e.idx = i; e.src = vecs[i].src; e.pc = vecs[i].pc; e.flush = vecs[i].flush;
      e.tt = vecs[i].tt; e.tc = vecs[i].tc; e.mt = vecs[i].mt;
      sb.push_back(e);
    end
    @(negedge clk_in);
    #1;
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
